// File: rtl/dmem_stall_ctrl_pkg.sv
// Shared types and helpers for the data-memory stall controller.
package dmem_stall_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // Misaligned word access or word index beyond the RAM.
  function automatic logic adr_err(input logic [XLEN-1:0] adr, input int unsigned depth);
    return (adr[1:0] != 2'b00) || ({2'b00, adr[XLEN-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_stall_ctrl_if.sv
// Core <-> data-memory bus. The master (core) drives the request fields;
// the slave (memory stage) returns load data, stall and the sticky error flag.
interface dmem_stall_ctrl_if;
  import dmem_stall_ctrl_pkg::*;

  // Handshake: a request is MemRead|MemWrite; the core must hold the request
  // fields stable and not advance while Stall=1. The cycle in which Stall drops
  // with the request still present is the completing cycle (ReadData valid).
  logic            MemRead;
  logic            MemWrite;
  logic [XLEN-1:0] DataAdr;
  logic [XLEN-1:0] WriteData;
  logic [XLEN-1:0] ReadData;
  logic            Stall;
  logic            MemErr;

  modport master (
    output MemRead, MemWrite, DataAdr, WriteData,
    input  ReadData, Stall, MemErr
  );

  modport slave (
    input  MemRead, MemWrite, DataAdr, WriteData,
    output ReadData, Stall, MemErr
  );

endinterface

// File: rtl/dmem_stall_ctrl_ram.sv
// Word RAM: synchronous write, asynchronous read, contents not reset.
module dmem_ram
  import dmem_stall_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_stall_ctrl.sv
// Data-memory stage: services core lw/sw from a word RAM with a fixed access
// latency, stalling the core until the access completes and flagging bad addresses.
module dmem_stall_ctrl
  import dmem_stall_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  dmem_stall_ctrl_if.slave    bus,
  output dmem_state_t         state_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  logic            req;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [XLEN-1:0] ram_wdata;
  logic [XLEN-1:0] ram_rdata;

  assign req = bus.MemRead | bus.MemWrite;

  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  if (LATENCY == 0) begin : g_bypass
    logic err;
    logic err_q;

    assign err = adr_err(bus.DataAdr, DEPTH);

    always_ff @(posedge clk) begin
      if (reset) begin
        err_q <= 1'b0;
      end else if (req && err) begin
        err_q <= 1'b1;
      end
    end

    // Reset on the request edge aborts the store.
    assign ram_we       = bus.MemWrite & ~err & ~reset;
    assign ram_addr     = bus.DataAdr[AW+1:2];
    assign ram_wdata    = bus.WriteData;
    assign bus.ReadData = err ? '0 : ram_rdata;
    assign bus.Stall    = 1'b0;
    assign bus.MemErr   = err_q;
    assign state_o      = IDLE;
  end else begin : g_fsm
    dmem_state_t     state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] cap_adr_q;
    logic [XLEN-1:0] cap_data_q;
    logic            cap_we_q;
    logic            err_q;
    logic            cap_err;

    assign cap_err = adr_err(cap_adr_q, DEPTH);

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        cap_adr_q  <= '0;
        cap_data_q <= '0;
        cap_we_q   <= 1'b0;
        err_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (req) begin
              cap_adr_q  <= bus.DataAdr;
              cap_data_q <= bus.WriteData;
              cap_we_q   <= bus.MemWrite;
              cnt_q      <= CW'(LATENCY - 1);
              state_q    <= (LATENCY == 1) ? DONE : WAIT;
            end
          end
          WAIT: begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_q <= DONE;
            end
          end
          DONE: begin
            if (cap_err) begin
              err_q <= 1'b1;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    // The store lands on the edge that ends DONE, unless reset aborts it.
    assign ram_we       = (state_q == DONE) & cap_we_q & ~cap_err & ~reset;
    assign ram_addr     = cap_adr_q[AW+1:2];
    assign ram_wdata    = cap_data_q;
    assign bus.ReadData = ((state_q == DONE) && !cap_err) ? ram_rdata : '0;
    assign bus.Stall    = ((state_q == IDLE) && req) || (state_q == WAIT);
    assign bus.MemErr   = err_q;
    assign state_o      = state_q;
  end

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Directed bench: cycle-by-cycle vector table for the LATENCY=2 stage plus a
// hand-written sequence for the LATENCY=0 pass-through stage.
module tb_dmem_stall_ctrl;
  import dmem_stall_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst2 = 1'b1;
  logic rst0 = 1'b1;
  dmem_state_t state2;
  dmem_state_t state0;

  int checks = 0;
  int errors = 0;

  dmem_stall_ctrl_if bus2 ();
  dmem_stall_ctrl_if bus0 ();

  dmem_stall_ctrl #(.DEPTH(256), .LATENCY(2)) dut2 (
    .clk(clk), .reset(rst2), .bus(bus2), .state_o(state2)
  );

  dmem_stall_ctrl #(.DEPTH(256), .LATENCY(0)) dut0 (
    .clk(clk), .reset(rst0), .bus(bus0), .state_o(state0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rd;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        e_stall;
    logic        chk_rd;
    logic [31:0] e_rd;
    logic        e_err;
    dmem_state_t e_state;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic rst, rd, wr, input logic [31:0] adr, wd,
                     input logic e_stall, chk_rd, input logic [31:0] e_rd,
                     input logic e_err, input dmem_state_t e_state);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.adr = adr; v.wd = wd;
    v.e_stall = e_stall; v.chk_rd = chk_rd; v.e_rd = e_rd;
    v.e_err = e_err; v.e_state = e_state;
    vecs.push_back(v);
  endtask

  // One full LATENCY=2 access: two stalled cycles then the DONE cycle.
  task automatic acc(input logic rd, wr, input logic [31:0] adr, wd,
                     input logic chk, input logic [31:0] e_rd, input logic err);
    row(1'b0, rd, wr, adr, wd, 1'b1, 1'b1, 32'd0, err, IDLE);
    row(1'b0, rd, wr, adr, wd, 1'b1, 1'b1, 32'd0, err, WAIT);
    row(1'b0, rd, wr, adr, wd, 1'b0, chk,  e_rd,  err, DONE);
  endtask

  task automatic idle_row(input logic err);
    row(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, err, IDLE);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic rd, wr, input logic [31:0] adr, wd);
    @(posedge clk);
    #1;
    rst0           = 1'b0;
    bus0.MemRead   = rd;
    bus0.MemWrite  = wr;
    bus0.DataAdr   = adr;
    bus0.WriteData = wd;
    @(negedge clk);
  endtask

  initial begin
    bus2.MemRead = 1'b0; bus2.MemWrite = 1'b0; bus2.DataAdr = '0; bus2.WriteData = '0;
    bus0.MemRead = 1'b0; bus0.MemWrite = 1'b0; bus0.DataAdr = '0; bus0.WriteData = '0;

    // reset state
    row(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, IDLE);
    row(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, IDLE);
    // sw 100<-25, then lw 100
    acc(1'b0, 1'b1, 32'd100, 32'd25, 1'b0, 32'd0, 1'b0);
    idle_row(1'b0);
    acc(1'b1, 1'b0, 32'd100, 32'd0, 1'b1, 32'd25, 1'b0);
    idle_row(1'b0);
    // back-to-back sw 96<-7, lw 96
    acc(1'b0, 1'b1, 32'd96, 32'd7, 1'b0, 32'd0, 1'b0);
    acc(1'b1, 1'b0, 32'd96, 32'd0, 1'b1, 32'd7, 1'b0);
    // seed RAM[50], then sw 104<-9 with DataAdr/WriteData changed mid-stall
    acc(1'b0, 1'b1, 32'd200, 32'h55, 1'b0, 32'd0, 1'b0);
    row(1'b0, 1'b0, 1'b1, 32'd104, 32'd9,   1'b1, 1'b1, 32'd0, 1'b0, IDLE);
    row(1'b0, 1'b0, 1'b1, 32'd200, 32'h77,  1'b1, 1'b1, 32'd0, 1'b0, WAIT);
    row(1'b0, 1'b0, 1'b1, 32'd200, 32'h77,  1'b0, 1'b0, 32'd0, 1'b0, DONE);
    acc(1'b1, 1'b0, 32'd104, 32'd0, 1'b1, 32'd9, 1'b0);
    acc(1'b1, 1'b0, 32'd200, 32'd0, 1'b1, 32'h55, 1'b0);
    // MemRead and MemWrite together behave as a store
    acc(1'b1, 1'b1, 32'd8, 32'h33, 1'b0, 32'd0, 1'b0);
    acc(1'b1, 1'b0, 32'd8, 32'd0, 1'b1, 32'h33, 1'b0);
    // seed RAM[0], then misaligned and out-of-range stores
    acc(1'b0, 1'b1, 32'd0, 32'h11, 1'b0, 32'd0, 1'b0);
    acc(1'b0, 1'b1, 32'd102, 32'hDEAD, 1'b1, 32'd0, 1'b0);
    idle_row(1'b1);
    acc(1'b0, 1'b1, 32'd4096, 32'hBEEF, 1'b1, 32'd0, 1'b1);
    acc(1'b1, 1'b0, 32'd100, 32'd0, 1'b1, 32'd25, 1'b1);
    acc(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 32'h11, 1'b1);
    acc(1'b1, 1'b0, 32'd101, 32'd0, 1'b1, 32'd0, 1'b1);
    // reset during WAIT of sw 100<-AA aborts the store and clears MemErr
    row(1'b0, 1'b0, 1'b1, 32'd100, 32'hAA, 1'b1, 1'b1, 32'd0, 1'b1, IDLE);
    row(1'b1, 1'b0, 1'b1, 32'd100, 32'hAA, 1'b1, 1'b1, 32'd0, 1'b1, WAIT);
    idle_row(1'b0);
    acc(1'b1, 1'b0, 32'd100, 32'd0, 1'b1, 32'd25, 1'b0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst2           = vecs[i].rst;
      bus2.MemRead   = vecs[i].rd;
      bus2.MemWrite  = vecs[i].wr;
      bus2.DataAdr   = vecs[i].adr;
      bus2.WriteData = vecs[i].wd;
      @(negedge clk);
      check($sformatf("row%0d stall", i), {31'd0, bus2.Stall}, {31'd0, vecs[i].e_stall});
      check($sformatf("row%0d memerr", i), {31'd0, bus2.MemErr}, {31'd0, vecs[i].e_err});
      check($sformatf("row%0d state", i), 32'(state2), 32'(vecs[i].e_state));
      if (vecs[i].chk_rd) begin
        check($sformatf("row%0d readdata", i), bus2.ReadData, vecs[i].e_rd);
      end
    end

    // LATENCY=0: no stall, same-cycle read data, error on the request edge
    drive0(1'b0, 1'b1, 32'd100, 32'd25);
    check("l0 sw stall", {31'd0, bus0.Stall}, 32'd0);
    check("l0 reset memerr", {31'd0, bus0.MemErr}, 32'd0);
    drive0(1'b1, 1'b0, 32'd100, 32'd0);
    check("l0 lw stall", {31'd0, bus0.Stall}, 32'd0);
    check("l0 lw readdata", bus0.ReadData, 32'd25);
    drive0(1'b0, 1'b1, 32'd101, 32'h99);
    check("l0 bad sw stall", {31'd0, bus0.Stall}, 32'd0);
    check("l0 bad sw memerr before edge", {31'd0, bus0.MemErr}, 32'd0);
    drive0(1'b1, 1'b0, 32'd4096, 32'd0);
    check("l0 memerr sticky", {31'd0, bus0.MemErr}, 32'd1);
    check("l0 out-of-range readdata", bus0.ReadData, 32'd0);
    drive0(1'b1, 1'b0, 32'd100, 32'd0);
    check("l0 lw after bad sw", bus0.ReadData, 32'd25);
    check("l0 memerr still set", {31'd0, bus0.MemErr}, 32'd1);
    check("l0 state", 32'(state0), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
